// File: rtl/perips_bus_arb.sv
// perips_bus_arb
// Two-master round-robin arbiter and sequencer for the single peripheral bus
// port. Exactly one transaction is in flight at a time: a master request is
// captured in IDLE, presented to the slave in REQ, the ack is awaited in WAIT
// (bounded by a timeout that substitutes ERR_DATA), returned to the issuing
// master in RESP, and, after a timeout, the late slave ack is swallowed in DRAIN.
//
// Ports
//   clk, rst_n                   : clock, asynchronous active-low reset
//   mN_req_* (N=0,1)             : master request channel (vld/rdy + payload)
//   mN_ack_* (N=0,1)             : response channel back to master N
//   s_req_*                      : request channel to the peripheral port
//   s_ack_*                      : response channel from the peripheral port
//   busy                         : FSM is not IDLE
//   grant_id                     : master owning the current transaction
//   timeout_err                  : one-cycle pulse when a timeout fires
module perips_bus_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_vld,
  output logic        m0_req_rdy,
  input  logic [31:0] m0_req_addr,
  input  logic [31:0] m0_req_data,
  input  logic [3:0]  m0_req_strb,
  input  logic        m0_req_opcode,
  output logic        m0_ack_vld,
  input  logic        m0_ack_rdy,
  output logic [31:0] m0_ack_data,
  input  logic        m1_req_vld,
  output logic        m1_req_rdy,
  input  logic [31:0] m1_req_addr,
  input  logic [31:0] m1_req_data,
  input  logic [3:0]  m1_req_strb,
  input  logic        m1_req_opcode,
  output logic        m1_ack_vld,
  input  logic        m1_ack_rdy,
  output logic [31:0] m1_ack_data,
  output logic        s_req_vld,
  input  logic        s_req_rdy,
  output logic [31:0] s_req_addr,
  output logic [31:0] s_req_data,
  output logic [3:0]  s_req_strb,
  output logic        s_req_opcode,
  input  logic        s_ack_vld,
  output logic        s_ack_rdy,
  input  logic [31:0] s_ack_data,
  output logic        busy,
  output logic        grant_id,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_rr_ptr;
  logic        r_grant_id;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [3:0]  r_strb;
  logic        r_opcode;
  logic [31:0] r_ack_data;
  logic        r_err;
  logic [15:0] r_cnt;
  logic        r_s_req_vld;
  logic        r_s_ack_rdy;
  logic        r_m0_ack_vld;
  logic        r_m1_ack_vld;
  logic        r_busy;
  logic        r_timeout_err;

  logic        w_win;
  logic        w_grant_hs;
  logic        w_m_ack_rdy;
  logic        w_to_fire;
  logic        w_s_req_vld_nxt;
  logic        w_s_ack_rdy_nxt;
  logic        w_m0_ack_vld_nxt;
  logic        w_m1_ack_vld_nxt;
  logic        w_busy_nxt;

  // Arbitration: a lone requester wins outright; on contention rr_ptr decides.
  assign w_win      = (m0_req_vld && m1_req_vld) ? r_rr_ptr : m1_req_vld;
  assign w_grant_hs = (r_state == ST_IDLE) && (m0_req_vld || m1_req_vld);
  assign m0_req_rdy = (r_state == ST_IDLE) && m0_req_vld && !w_win;
  assign m1_req_rdy = (r_state == ST_IDLE) && m1_req_vld &&  w_win;

  assign w_m_ack_rdy = r_grant_id ? m1_ack_rdy : m0_ack_rdy;
  // A slave ack arriving in the timeout cycle takes precedence over the error.
  assign w_to_fire   = (r_state == ST_WAIT) && !s_ack_vld && (r_cnt == LP_TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state plus the next value of every registered handshake output, so
  // those outputs switch on the same edge as the state they belong to.
  always_comb begin
    w_next           = r_state;
    w_s_req_vld_nxt  = 1'b0;
    w_s_ack_rdy_nxt  = 1'b0;
    w_m0_ack_vld_nxt = 1'b0;
    w_m1_ack_vld_nxt = 1'b0;
    w_busy_nxt       = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (w_grant_hs) w_next = ST_REQ;
      ST_REQ:   if (s_req_rdy) w_next = ST_WAIT;
      ST_WAIT:  if (s_ack_vld || w_to_fire) w_next = ST_RESP;
      ST_RESP:  if (w_m_ack_rdy) w_next = r_err ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (s_ack_vld) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    w_s_req_vld_nxt  = (w_next == ST_REQ);
    w_s_ack_rdy_nxt  = (w_next == ST_WAIT) || (w_next == ST_DRAIN);
    w_m0_ack_vld_nxt = (w_next == ST_RESP) && !r_grant_id;
    w_m1_ack_vld_nxt = (w_next == ST_RESP) &&  r_grant_id;
    w_busy_nxt       = (w_next != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_req_vld   <= 1'b0;
      r_s_ack_rdy   <= 1'b0;
      r_m0_ack_vld  <= 1'b0;
      r_m1_ack_vld  <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_s_req_vld   <= w_s_req_vld_nxt;
      r_s_ack_rdy   <= w_s_ack_rdy_nxt;
      r_m0_ack_vld  <= w_m0_ack_vld_nxt;
      r_m1_ack_vld  <= w_m1_ack_vld_nxt;
      r_busy        <= w_busy_nxt;
      r_timeout_err <= w_to_fire;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= 1'b0;
      r_grant_id <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_strb     <= '0;
      r_opcode   <= 1'b0;
      r_ack_data <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_grant_hs) begin
        r_grant_id <= w_win;
        r_rr_ptr   <= ~w_win;
        r_addr     <= w_win ? m1_req_addr   : m0_req_addr;
        r_data     <= w_win ? m1_req_data   : m0_req_data;
        r_strb     <= w_win ? m1_req_strb   : m0_req_strb;
        r_opcode   <= w_win ? m1_req_opcode : m0_req_opcode;
      end
      // Cleared on WAIT entry, so the 16-bit counter never reaches its wrap.
      if (r_state == ST_REQ && s_req_rdy) r_cnt <= '0;
      else if (r_state == ST_WAIT)        r_cnt <= r_cnt + 16'd1;
      if (r_state == ST_WAIT) begin
        if (s_ack_vld) begin
          r_ack_data <= s_ack_data;
          r_err      <= 1'b0;
        end else if (w_to_fire) begin
          r_ack_data <= ERR_DATA;
          r_err      <= 1'b1;
        end
      end
    end
  end

  assign s_req_vld    = r_s_req_vld;
  assign s_req_addr   = r_addr;
  assign s_req_data   = r_data;
  assign s_req_strb   = r_strb;
  assign s_req_opcode = r_opcode;
  assign s_ack_rdy    = r_s_ack_rdy;
  assign m0_ack_vld   = r_m0_ack_vld;
  assign m1_ack_vld   = r_m1_ack_vld;
  assign m0_ack_data  = r_ack_data;
  assign m1_ack_data  = r_ack_data;
  assign busy         = r_busy;
  assign grant_id     = r_grant_id;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_perips_bus_arb.sv
// tb_perips_bus_arb
// Self-checking bench for perips_bus_arb (built with an 8-cycle timeout).
// Single-master transactions come from a vector table; contention, timeout
// with drain, and reset during WAIT are hand-written sequences. Expected slave
// requests and master responses flow through two scoreboard queues.
module tb_perips_bus_arb;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req_vld, m0_req_rdy, m0_req_opcode, m0_ack_vld, m0_ack_rdy;
  logic [31:0] m0_req_addr, m0_req_data, m0_ack_data;
  logic [3:0]  m0_req_strb;
  logic        m1_req_vld, m1_req_rdy, m1_req_opcode, m1_ack_vld, m1_ack_rdy;
  logic [31:0] m1_req_addr, m1_req_data, m1_ack_data;
  logic [3:0]  m1_req_strb;
  logic        s_req_vld, s_req_rdy, s_req_opcode, s_ack_vld, s_ack_rdy;
  logic [31:0] s_req_addr, s_req_data, s_ack_data;
  logic [3:0]  s_req_strb;
  logic        busy, grant_id, timeout_err;

  always #5 clk = ~clk;

  perips_bus_arb #(.TIMEOUT_CYCLES(TO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_vld(m0_req_vld), .m0_req_rdy(m0_req_rdy), .m0_req_addr(m0_req_addr),
    .m0_req_data(m0_req_data), .m0_req_strb(m0_req_strb), .m0_req_opcode(m0_req_opcode),
    .m0_ack_vld(m0_ack_vld), .m0_ack_rdy(m0_ack_rdy), .m0_ack_data(m0_ack_data),
    .m1_req_vld(m1_req_vld), .m1_req_rdy(m1_req_rdy), .m1_req_addr(m1_req_addr),
    .m1_req_data(m1_req_data), .m1_req_strb(m1_req_strb), .m1_req_opcode(m1_req_opcode),
    .m1_ack_vld(m1_ack_vld), .m1_ack_rdy(m1_ack_rdy), .m1_ack_data(m1_ack_data),
    .s_req_vld(s_req_vld), .s_req_rdy(s_req_rdy), .s_req_addr(s_req_addr),
    .s_req_data(s_req_data), .s_req_strb(s_req_strb), .s_req_opcode(s_req_opcode),
    .s_ack_vld(s_ack_vld), .s_ack_rdy(s_ack_rdy), .s_ack_data(s_ack_data),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  typedef struct {
    bit          m;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        op;
  } sreq_t;

  typedef struct {
    bit          m;
    logic [31:0] data;
  } ack_t;

  typedef struct {
    bit          m;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        op;
    int          req_stall;
    int          ack_lat;
    logic [31:0] slv_data;
    int          ack_stall;
    bit          exp_gid;
    logic [31:0] exp_resp;
  } vec_t;

  sreq_t sq[$];
  ack_t  aq[$];
  int    n_chk = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive_m(input bit m, input logic v, input sreq_t p);
    if (m) begin
      m1_req_vld = v; m1_req_addr = p.addr; m1_req_data = p.data;
      m1_req_strb = p.strb; m1_req_opcode = p.op;
    end else begin
      m0_req_vld = v; m0_req_addr = p.addr; m0_req_data = p.data;
      m0_req_strb = p.strb; m0_req_opcode = p.op;
    end
  endtask

  // Compare the presented slave request with the oldest expected one.
  task automatic pop_sreq(input string tag);
    sreq_t e;
    if (sq.size() == 0) begin
      n_chk++; n_err++;
      $display("FAIL %s_sq: got a slave request, expected none", tag);
    end else begin
      e = sq.pop_front();
      chk({tag, "_gid"},  {31'd0, grant_id}, {31'd0, e.m});
      chk({tag, "_addr"}, s_req_addr, e.addr);
      chk({tag, "_data"}, s_req_data, e.data);
      chk({tag, "_strb"}, {28'd0, s_req_strb}, {28'd0, e.strb});
      chk({tag, "_op"},   {31'd0, s_req_opcode}, {31'd0, e.op});
    end
  endtask

  // Compare the master response currently presented with the oldest expected one.
  task automatic pop_ack(input string tag);
    ack_t e;
    if (aq.size() == 0) begin
      n_chk++; n_err++;
      $display("FAIL %s_aq: got a master ack, expected none", tag);
    end else begin
      e = aq.pop_front();
      chk({tag, "_both"}, {31'd0, m0_ack_vld & m1_ack_vld}, 32'd0);
      chk({tag, "_own"},  {31'd0, e.m ? m1_ack_vld : m0_ack_vld}, 32'd1);
      chk({tag, "_data"}, e.m ? m1_ack_data : m0_ack_data, e.data);
    end
  endtask

  task automatic do_txn(input vec_t v);
    sreq_t p, p_junk, p_oth;
    p      = '{v.m, v.addr, v.data, v.strb, v.op};
    p_junk = '{v.m, ~v.addr, ~v.data, ~v.strb, ~v.op};
    p_oth  = '{~v.m, 32'h3000_0000, 32'h3333_3333, 4'hF, 1'b1};
    drive_m(v.m, 1'b1, p);
    #1;
    chk("rdy_win",  {31'd0, v.m ? m1_req_rdy : m0_req_rdy}, 32'd1);
    chk("rdy_lose", {31'd0, v.m ? m0_req_rdy : m1_req_rdy}, 32'd0);
    sq.push_back(p);
    tick;
    // Scrambled payload after the handshake: the DUT must present the captured copy.
    drive_m(v.m, 1'b0, p_junk);
    chk("req_busy", {31'd0, busy}, 32'd1);
    chk("req_gid",  {31'd0, grant_id}, {31'd0, v.exp_gid});
    for (int i = 0; i < v.req_stall; i++) begin
      drive_m(~v.m, 1'b1, p_oth);
      #1;
      chk("stall_oth_rdy", {31'd0, v.m ? m0_req_rdy : m1_req_rdy}, 32'd0);
      chk("stall_vld",  {31'd0, s_req_vld}, 32'd1);
      chk("stall_addr", s_req_addr, v.addr);
      chk("stall_data", s_req_data, v.data);
      tick;
    end
    drive_m(~v.m, 1'b0, p_oth);
    s_req_rdy = 1'b1;
    chk("sreq_vld", {31'd0, s_req_vld}, 32'd1);
    pop_sreq("sreq");
    tick;
    s_req_rdy = 1'b0;
    for (int i = 0; i < v.ack_lat; i++) begin
      chk("wait_rdy", {29'd0, s_ack_rdy, s_req_vld, timeout_err}, 32'b100);
      chk("wait_mack", {30'd0, m1_ack_vld, m0_ack_vld}, 32'd0);
      tick;
    end
    s_ack_vld  = 1'b1;
    s_ack_data = v.slv_data;
    aq.push_back('{v.exp_gid, v.exp_resp});
    tick;
    s_ack_vld  = 1'b0;
    s_ack_data = 32'h0;
    chk("resp_to", {31'd0, timeout_err}, 32'd0);
    for (int i = 0; i < v.ack_stall; i++) begin
      chk("resp_hold", {30'd0, m1_ack_vld, m0_ack_vld}, v.m ? 32'b10 : 32'b01);
      tick;
    end
    if (v.m) m1_ack_rdy = 1'b1; else m0_ack_rdy = 1'b1;
    pop_ack("mack");
    tick;
    m0_ack_rdy = 1'b0;
    m1_ack_rdy = 1'b0;
    chk("idle_after", {28'd0, busy, s_ack_rdy, m1_ack_vld, m0_ack_vld}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs[5];
    sreq_t pz;
    sreq_t p0, p1;
    int    i0, i1, ngr, nack;
    bit    w;

    pz = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0};
    drive_m(1'b0, 1'b0, pz);
    drive_m(1'b1, 1'b0, pz);
    m0_ack_rdy = 1'b0; m1_ack_rdy = 1'b0;
    s_req_rdy = 1'b0; s_ack_vld = 1'b0; s_ack_data = 32'h0;
    rst_n = 1'b0;

    // m, addr, data, strb, op, req_stall, ack_lat, slave data, ack_stall, exp gid, exp resp
    vecs[0] = '{1'b0, 32'h1000_0004, 32'h0000_0000, 4'hF, 1'b0, 0, 3,    32'h0000_00A5, 0, 1'b0, 32'h0000_00A5};
    vecs[1] = '{1'b1, 32'h1000_0010, 32'h1234_5678, 4'h3, 1'b1, 10, 0,   32'h0000_0000, 2, 1'b1, 32'h0000_0000};
    vecs[2] = '{1'b0, 32'h1000_1000, 32'h8765_4321, 4'hC, 1'b1, 1, 1,    32'h0000_0001, 1, 1'b0, 32'h0000_0001};
    vecs[3] = '{1'b1, 32'h1000_2008, 32'h0000_0000, 4'hF, 1'b0, 0, 6,    32'hCAFE_F00D, 0, 1'b1, 32'hCAFE_F00D};
    // Ack lands in the very cycle the timeout would fire: real data, no error, no drain.
    vecs[4] = '{1'b0, 32'h1000_3000, 32'h0000_0000, 4'hF, 1'b0, 0, TO-1, 32'h5555_AAAA, 0, 1'b0, 32'h5555_AAAA};

    repeat (3) @(posedge clk);
    #2;
    chk("rst_ctl", {26'd0, s_req_vld, s_ack_rdy, m0_ack_vld, m1_ack_vld, busy, timeout_err}, 32'd0);
    chk("rst_gid", {31'd0, grant_id}, 32'd0);
    chk("rst_saddr", s_req_addr, 32'd0);
    chk("rst_sdata", s_req_data, 32'd0);
    chk("rst_m0data", m0_ack_data, 32'd0);
    chk("rst_m1data", m1_ack_data, 32'd0);
    rst_n = 1'b1;
    tick;

    // Both masters valid from reset, three writes each: grants must alternate.
    i0 = 0; i1 = 0; ngr = 0; nack = 0;
    s_req_rdy = 1'b1; m0_ack_rdy = 1'b1; m1_ack_rdy = 1'b1;
    for (int cyc = 0; cyc < 100 && nack < 6; cyc++) begin
      p0 = '{1'b0, 32'h2000_0000 + 32'(i0 * 4), 32'h1111_0000 | 32'(i0), 4'hF, 1'b1};
      p1 = '{1'b1, 32'h2100_0000 + 32'(i1 * 4), 32'h2222_0000 | 32'(i1), 4'hF, 1'b1};
      drive_m(1'b0, i0 < 3, p0);
      drive_m(1'b1, i1 < 3, p1);
      #1;
      w = 1'b0;
      if (m0_req_rdy || m1_req_rdy) begin
        w = m1_req_rdy;
        chk("rr_onehot", {31'd0, m0_req_rdy & m1_req_rdy}, 32'd0);
        chk("rr_order", {31'd0, w}, ngr % 2);
        sq.push_back(w ? p1 : p0);
      end
      if (s_req_vld) pop_sreq("rr_sreq");
      if (s_ack_rdy) begin
        s_ack_vld  = 1'b1;
        s_ack_data = 32'hA000_0000 | 32'(nack);
        aq.push_back('{grant_id, 32'hA000_0000 | 32'(nack)});
      end else begin
        s_ack_vld = 1'b0;
      end
      if (m0_ack_vld || m1_ack_vld) begin
        pop_ack("rr_mack");
        nack++;
      end
      if (m0_req_rdy || m1_req_rdy) begin
        ngr++;
        if (w) i1++; else i0++;
      end
      tick;
    end
    chk("rr_done", nack, 6);
    s_req_rdy = 1'b0; s_ack_vld = 1'b0; m0_ack_rdy = 1'b0; m1_ack_rdy = 1'b0;
    drive_m(1'b0, 1'b0, pz);
    drive_m(1'b1, 1'b0, pz);
    tick;

    for (int k = 0; k < 5; k++) do_txn(vecs[k]);

    // Silent slave: timeout after TO WAIT cycles, error data to m1, then drain.
    p1 = '{1'b1, 32'h1000_4000, 32'h0, 4'hF, 1'b0};
    drive_m(1'b1, 1'b1, p1);
    sq.push_back(p1);
    tick;
    drive_m(1'b1, 1'b0, pz);
    s_req_rdy = 1'b1;
    pop_sreq("to_sreq");
    tick;
    s_req_rdy = 1'b0;
    aq.push_back('{1'b1, 32'hDEAD_BEEF});
    for (int i = 0; i < TO; i++) begin
      chk("to_wait", {29'd0, s_ack_rdy, m1_ack_vld, timeout_err}, 32'b100);
      tick;
    end
    chk("to_pulse", {31'd0, timeout_err}, 32'd1);
    tick;
    chk("to_pulse_end", {31'd0, timeout_err}, 32'd0);
    m1_ack_rdy = 1'b1;
    pop_ack("to_mack");
    tick;
    m1_ack_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("drain_hold", {28'd0, busy, s_ack_rdy, m1_ack_vld, m0_ack_vld}, 32'b1100);
      tick;
    end
    s_ack_vld = 1'b1; s_ack_data = 32'h7777_7777;
    tick;
    s_ack_vld = 1'b0;
    chk("drain_exit", {28'd0, busy, s_ack_rdy, m1_ack_vld, m0_ack_vld}, 32'd0);
    tick;
    chk("drain_noack", {30'd0, m1_ack_vld, m0_ack_vld}, 32'd0);

    // Reset pulsed while WAITing on the slave: everything drops asynchronously.
    p1 = '{1'b1, 32'h1000_5000, 32'h0, 4'hF, 1'b0};
    drive_m(1'b1, 1'b1, p1);
    sq.push_back(p1);
    tick;
    drive_m(1'b1, 1'b0, pz);
    s_req_rdy = 1'b1;
    pop_sreq("ar_sreq");
    tick;
    s_req_rdy = 1'b0;
    tick;
    chk("ar_inwait", {31'd0, s_ack_rdy}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_ctl", {26'd0, s_req_vld, s_ack_rdy, m0_ack_vld, m1_ack_vld, busy, timeout_err}, 32'd0);
    chk("ar_gid", {31'd0, grant_id}, 32'd0);
    chk("ar_saddr", s_req_addr, 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("ar_noack", {29'd0, busy, m1_ack_vld, m0_ack_vld}, 32'd0);
    do_txn('{1'b1, 32'h1000_6000, 32'hABCD_0123, 4'h5, 1'b1, 0, 2, 32'h0BAD_F00D, 0, 1'b1, 32'h0BAD_F00D});

    chk("sq_empty", sq.size(), 0);
    chk("aq_empty", aq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/perips_bus_arb.md
# perips_bus_arb

Two-master round-robin arbiter and sequencer for the single peripheral bus port (`peripheral_out0_*`) that feeds the peripheral subsystem (bus-to-APB bridge, then UART and GPIO). It lets the core load/store path (m0) and a second requester such as the debug module or a DMA (m1) share the port. It keeps exactly one transaction outstanding, routes the ack back to the master that issued the request, and bounds ack latency with a timeout that returns an error response.

## Interface
- `TIMEOUT_CYCLES`, default 1024: number of WAIT cycles without a slave ack before a timeout fires. Legal range 2..65535.
- `ERR_DATA`, default 32'hDEAD_BEEF: ack data returned to the master on a timeout.
- `clk` in 1: clock. This block has exactly one clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `mN_req_vld` in 1, N=0,1: master request valid.
- `mN_req_rdy` out 1: request accepted by the arbiter.
- `mN_req_addr` in 32, `mN_req_data` in 32, `mN_req_strb` in 4, `mN_req_opcode` in 1: request payload.
- `mN_ack_vld` out 1, `mN_ack_rdy` in 1, `mN_ack_data` out 32: response channel to master N.
- `s_req_vld` out 1, `s_req_rdy` in 1: request to the peripheral port.
- `s_req_addr` out 32, `s_req_data` out 32, `s_req_strb` out 4, `s_req_opcode` out 1: request payload to the peripheral port.
- `s_ack_vld` in 1, `s_ack_rdy` out 1, `s_ack_data` in 32: response from the peripheral port.
- `busy` out 1: state is not IDLE.
- `grant_id` out 1: master owning the current transaction. Valid while `busy` is high.
- `timeout_err` out 1: one-cycle pulse when a timeout fires.

## Operation
- The FSM has five states: IDLE, REQ, WAIT, RESP, DRAIN. Reset state is IDLE.
- IDLE:
  - Grant is combinational. The winner is the only valid master; if both are valid, the master selected by `rr_ptr`.
  - `mN_req_rdy` is high only for the granted master, and only in IDLE.
  - On the handshake, capture addr/data/strb/opcode into holding registers. Set `grant_id` to the winner and `rr_ptr` to the other master. Go to REQ.
- REQ:
  - `s_req_vld`=1 with the held payload, stable until `s_req_rdy`.
  - The opcode passes through unchanged.
  - On `s_req_rdy`, go to WAIT and clear the timeout counter.
- WAIT:
  - `s_ack_rdy`=1. The counter increments each cycle.
  - On `s_ack_vld`, capture `s_ack_data` and go to RESP with the error flag cleared.
  - Otherwise, when the counter reaches `TIMEOUT_CYCLES`-1: load `ERR_DATA`, pulse `timeout_err`, set the error flag, and go to RESP.
  - If `s_ack_vld` arrives in the same cycle as the timeout, the ack wins and no error occurs.
- RESP:
  - Only the granted master sees `mN_ack_vld`=1 with the captured data, held until `mN_ack_rdy`.
  - On the handshake, go to IDLE if the error flag is clear, or to DRAIN if it is set.
- DRAIN:
  - `s_ack_rdy`=1. The late slave ack is consumed and discarded, then go to IDLE.
  - There is no timeout in DRAIN.
- Only one transaction is outstanding at any time. No new grant is issued until the FSM is back in IDLE.
- The counter is 16 bits wide and does not wrap, because it is cleared on entry to WAIT.

## Timing
- Reset values:
  - All `mN_req_rdy`, `mN_ack_vld`, `s_req_vld`, `s_ack_rdy`, `busy`, `timeout_err` = 0.
  - All data/addr outputs = 0.
  - `grant_id` = 0, `rr_ptr` = 0 (m0 has priority first).
- Minimum latency with zero-wait slave ack:
  - Master handshake in cycle 0.
  - `s_req_vld` in cycle 1. With `s_req_rdy`=1 there, WAIT in cycle 2.
  - `s_ack_vld` in cycle 2 gives `mN_ack_vld` in cycle 3.
  - With `mN_ack_rdy`=1, IDLE in cycle 4. The next grant is possible in cycle 4.
- All outputs are registered except `mN_req_rdy`, which is a combinational function of state, `rr_ptr` and `mN_req_vld`.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and all valids drop. No ack is produced for the aborted transaction.
- A master that drops `req_vld` before being granted is legal. No state changes.

## Test plan
- Single m0 read to addr 0x1000_0004, slave acks with 0x0000_00A5 after 3 cycles -> `m0_ack_data`=0xA5. `m1_ack_vld` never asserts. `s_req_addr`=0x1000_0004 stable during REQ.
- m0 and m1 both valid from reset, each issuing 3 back-to-back writes -> grant order m0,m1,m0,m1,m0,m1. Each ack goes only to the issuer. Payloads (data 0x11.., 0x22..) unaltered at the slave side.
- `s_req_rdy` held low 10 cycles -> `s_req_vld` and payload stable all 10 cycles. `mN_req_rdy` stays 0 for the other master.
- `TIMEOUT_CYCLES`=8 with a silent slave -> `timeout_err` pulses once after 8 WAIT cycles and `m1_ack_data`=0xDEAD_BEEF. The FSM enters DRAIN. A late `s_ack_vld` 20 cycles later is consumed with no master ack. `busy` then falls.
- `s_ack_vld` in the exact timeout cycle -> real data is returned, no `timeout_err`, and the FSM goes RESP -> IDLE with no DRAIN.
- `rst_n` pulsed low during WAIT -> all outputs reach reset values asynchronously. After release, a new m1 request completes normally.
